// File: rtl/sign_narrow5_pkg.sv
// sign_narrow5_pkg -- shared widths, immediate limits and result type for the
// 8-to-5 bit signed narrowing pipeline (sign_narrow5).
//
// Contents:
//   DATA_W / IMM5_W   operand and immediate widths
//   IMM5_MAX/IMM5_MIN largest and smallest 5-bit signed immediates
//   ERR_CNT_MAX       saturation value of the error counter
//   narrow_res_t      {fit, imm} result of one narrowing operation
package sign_narrow5_pkg;

    localparam int DATA_W = 8;
    localparam int IMM5_W = 5;

    localparam logic [IMM5_W-1:0] IMM5_MAX    = 5'b01111;
    localparam logic [IMM5_W-1:0] IMM5_MIN    = 5'b10000;
    localparam logic [7:0]        ERR_CNT_MAX = 8'hFF;

    typedef struct packed {
        logic              fit;
        logic [IMM5_W-1:0] imm;
    } narrow_res_t;

endpackage

// File: rtl/sign_narrow5_if.sv
// sign_narrow5_if -- operand-in / immediate-out streaming bus of sign_narrow5.
//
// Signals:
//   in_valid, in_ready, in_data     operand channel (producer -> unit)
//   out_valid, out_ready            result channel (unit -> consumer)
//   out_imm, out_fit                narrowed immediate and fit flag
//
// Handshake: on both channels a transfer happens on a rising clk edge where
// valid && ready are both 1. The sender holds valid and its payload stable
// until that transfer; ready may change freely and never waits on valid.
//
// Modports:
//   master  producer/consumer side (test harness, upstream logic)
//   slave   the narrowing unit
interface sign_narrow5_if;
    import sign_narrow5_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [IMM5_W-1:0] out_imm;
    logic              out_fit;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_imm, out_fit
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_imm, out_fit
    );

endinterface

// File: rtl/sign_narrow5_core.sv
// narrow5_core -- combinational 8-to-5 bit signed narrowing.
//
// Ports:
//   data_i  8-bit two's-complement operand
//   res_o   {fit, imm}: fit = operand lies in -16..+15; imm = narrowed value
//
// Build option SIGN_NARROW_SAT_EN: when defined, out-of-range operands clamp to
// +15 / -16 by sign; otherwise they truncate to data_i[4:0].
module narrow5_core
    import sign_narrow5_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output narrow_res_t       res_o
);

    logic fit;

    // Fits exactly when bits 7..4 are all copies of the sign bit.
    assign fit = (data_i[7:4] == 4'b0000) || (data_i[7:4] == 4'b1111);

    always_comb begin
        res_o.fit = fit;
        res_o.imm = data_i[IMM5_W-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (!fit) begin
            res_o.imm = data_i[DATA_W-1] ? IMM5_MIN : IMM5_MAX;
        end
`endif
    end

endmodule

// File: rtl/sign_narrow5.sv
// sign_narrow5 -- two-stage pipeline narrowing 8-bit signed operands to the
// 5-bit signed immediate field, with range-error bookkeeping.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears the whole pipeline
//   bus         sign_narrow5_if.slave: in_valid/in_ready/in_data operand
//               channel, out_valid/out_ready/out_imm/out_fit result channel
//   err_clr     synchronous clear of err_sticky / err_count (wins over a
//               same-cycle error)
//   err_sticky  set by any non-fitting operand passing S1 -> S2
//   err_count   number of non-fitting operands, saturates at 255
//
// Build option SIGN_NARROW_SAT_EN selects saturate (defined) or truncate
// (undefined) for non-fitting operands; see narrow5_core.
//
// Stage 1 holds the raw operand; narrow5_core works on it combinationally.
// Stage 2 holds the result and drives the outputs. Latency is two cycles.
module sign_narrow5
    import sign_narrow5_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    sign_narrow5_if.slave       bus,
    input  logic                err_clr,
    output logic                err_sticky,
    output logic [7:0]          err_count
);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    narrow_res_t       s2_res_q,   s2_res_d;
    logic              err_sticky_q, err_sticky_d;
    logic [7:0]        err_count_q,  err_count_d;

    narrow_res_t       s1_res;
    logic              s1_adv;
    logic              s2_adv;
    logic              err_event;

    narrow5_core u_core (
        .data_i (s1_data_q),
        .res_o  (s1_res)
    );

    // A stage may load when it is empty or its contents move on this edge;
    // in_ready is therefore combinational from out_ready.
    assign s2_adv    = !s2_valid_q || bus.out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign err_event = s1_valid_q && s2_adv && !s1_res.fit;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        s2_valid_d   = s2_valid_q;
        s2_res_d     = s2_res_q;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d = bus.in_data;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = s1_res;
            end
        end

        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = 8'd0;
        end else if (err_event) begin
            err_sticky_d = 1'b1;
            if (err_count_q != ERR_CNT_MAX) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_res_q     <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            s2_valid_q   <= s2_valid_d;
            s2_res_q     <= s2_res_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_imm   = s2_res_q.imm;
    assign bus.out_fit   = s2_res_q.fit;
    assign err_sticky    = err_sticky_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_sign_narrow5.sv
// tb_sign_narrow5 -- directed self-checking bench for sign_narrow5.
// Expected {fit, imm} pairs are hand-computed; SIGN_NARROW_SAT_EN selects the
// expectations for out-of-range operands.
module tb_sign_narrow5;

    logic       clk;
    logic       rst_n;
    logic       err_clr;
    logic       err_sticky;
    logic [7:0] err_count;

    sign_narrow5_if bus ();

    sign_narrow5 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    // Hand-computed results for out-of-range operands, {fit, imm}.
`ifdef SIGN_NARROW_SAT_EN
    localparam logic [5:0] EXP_10 = 6'h0F;  // 0x10 -> +15
    localparam logic [5:0] EXP_80 = 6'h10;  // 0x80 -> -16
    localparam logic [5:0] EXP_40 = 6'h0F;  // 0x40 -> +15
`else
    localparam logic [5:0] EXP_10 = 6'h10;  // 0x10 -> low bits 10000
    localparam logic [5:0] EXP_80 = 6'h00;  // 0x80 -> low bits 00000
    localparam logic [5:0] EXP_40 = 6'h00;  // 0x40 -> low bits 00000
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every output handshake is compared against the oldest accepted operand.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                check("out_data", {26'd0, bus.out_fit, bus.out_imm}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    // One clock cycle with the given operand offered; pushes the expectation
    // if the operand was accepted. Returns shortly after the rising edge.
    task automatic cycle_in(input logic v, input logic [7:0] d, input logic [5:0] e,
                            output logic acc);
        bus.in_valid = v;
        bus.in_data  = d;
        @(negedge clk);
        acc = v && bus.in_ready;
        @(posedge clk);
        if (acc) exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle_in(1'b0, 8'h00, 6'h00, acc);
    endtask

    logic [7:0] bp_vals [4];
    logic [5:0] bp_exps [4];

    initial begin
        logic acc;
        int   idx;

        n_checks = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        err_clr       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b1;

        bp_vals[0] = 8'h01; bp_exps[0] = 6'h21;
        bp_vals[1] = 8'h02; bp_exps[1] = 6'h22;
        bp_vals[2] = 8'hFE; bp_exps[2] = 6'h3E;
        bp_vals[3] = 8'h05; bp_exps[3] = 6'h25;

        // ---- reset state ----
        #12;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_imm",   {27'd0, bus.out_imm},   32'd0);
        check("rst_out_fit",   {31'd0, bus.out_fit},   32'd0);
        check("rst_sticky",    {31'd0, err_sticky},    32'd0);
        check("rst_count",     {24'd0, err_count},     32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- boundary values, with explicit two-cycle latency ----
        cycle_in(1'b1, 8'h0F, 6'h2F, acc);
        check("lat_n1_valid", {31'd0, bus.out_valid}, 32'd0);
        cycle_in(1'b1, 8'hF0, 6'h30, acc);
        check("lat_n2_valid", {31'd0, bus.out_valid}, 32'd1);
        check("lat_n2_imm",   {27'd0, bus.out_imm},   32'h0F);
        cycle_in(1'b1, 8'h00, 6'h20, acc);
        check("lat_imm_f0",   {27'd0, bus.out_imm},   32'h10);
        cycle_in(1'b1, 8'hFF, 6'h3F, acc);
        check("lat_imm_00",   {27'd0, bus.out_imm},   32'h00);
        idle(1);
        check("lat_imm_ff",   {27'd0, bus.out_imm},   32'h1F);
        idle(2);
        check("bnd_sticky",   {31'd0, err_sticky},    32'd0);
        check("bnd_count",    {24'd0, err_count},     32'd0);

        // ---- out-of-range values ----
        cycle_in(1'b1, 8'h10, EXP_10, acc);
        cycle_in(1'b1, 8'h80, EXP_80, acc);
        idle(3);
        check("oor_count",  {24'd0, err_count},  32'd2);
        check("oor_sticky", {31'd0, err_sticky}, 32'd1);

        // ---- backpressure: out_ready low for the first 5 cycles ----
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            bus.out_ready = (c >= 5);
            cycle_in(idx < 4, (idx < 4) ? bp_vals[idx] : 8'h00,
                     (idx < 4) ? bp_exps[idx] : 6'h00, acc);
            if (acc) idx++;
            if (c >= 1 && c <= 4) begin
                check("bp_in_ready", {31'd0, bus.in_ready},  32'd0);
                check("bp_hold_vld", {31'd0, bus.out_valid}, 32'd1);
                check("bp_hold_imm", {27'd0, bus.out_imm},   32'h01);
                check("bp_accepted", idx,                    32'd2);
            end
        end
        check("bp_all_sent", idx,            32'd4);
        check("bp_drained",  exp_q.size(),   32'd0);

        // ---- counter saturation and clear priority ----
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 261; i++) begin
            cycle_in(1'b1, 8'h40, EXP_40, acc);
            if (!acc) check("sat_accept", 32'd0, 32'd1);
            // 2 earlier errors + (i-1) advanced so far from this stream
            if (i == 252) check("sat_cnt_253", {24'd0, err_count}, 32'd253);
            if (i == 254) check("sat_cnt_255", {24'd0, err_count}, 32'd255);
        end
        check("sat_hold_255", {24'd0, err_count},  32'd255);
        check("sat_sticky",   {31'd0, err_sticky}, 32'd1);
        // The last operand leaves S1 on this edge, an error in the same cycle
        bus.in_valid = 1'b0;
        err_clr      = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_count",  {24'd0, err_count},  32'd0);
        check("clr_sticky", {31'd0, err_sticky}, 32'd0);
        idle(3);
        check("clr_count_after", {24'd0, err_count}, 32'd0);
        check("sat_drained",     exp_q.size(),       32'd0);

        // ---- reset with both stages full ----
        bus.out_ready = 1'b0;
        cycle_in(1'b1, 8'h03, 6'h23, acc);
        cycle_in(1'b1, 8'h04, 6'h24, acc);
        bus.in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        check("pre_rst_ready", {31'd0, bus.in_ready},  32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready},  32'd1);
        check("mid_rst_imm",   {27'd0, bus.out_imm},   32'd0);
        exp_q.delete();
        bus.out_ready = 1'b1;
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sign_narrow5.md
# sign_narrow5

Pipelined narrowing unit converting 8-bit two's-complement values into the 5-bit signed immediate field used by the instruction encoding. It is the encode-side counterpart of the 5-to-8 sign extender, used by the assembler-assist and loader path. It reports for each value whether the value fits in 5 bits. A sticky range error and a saturating error counter are kept for software inspection.

## Interface
- No parameters; widths are fixed at 8 in and 5 out.
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data is presented
- in_ready  output  1  unit accepts in_data this cycle
- in_data  input  8  two's-complement operand
- out_valid  output  1  out_imm/out_fit are valid
- out_ready  input  1  downstream accepts this cycle
- out_imm  output  5  narrowed immediate
- out_fit  output  1  1 = in_data representable in 5 bits (-16..+15)
- err_sticky  output  1  set on any non-fitting accepted value
- err_count  output  8  number of non-fitting values, saturates at 255
- err_clr  input  1  synchronous clear of err_sticky and err_count

## Operation
- Accept on in_valid && in_ready. Emit on out_valid && out_ready.
- Fit rule: out_fit = (in_data[7:4] == 4'b0000) || (in_data[7:4] == 4'b1111).
- When fit: out_imm = in_data[4:0]. This is exact: sign-extending out_imm reproduces in_data.
- When not fit: out_imm is set by the configuration. See Configuration.
- Stage 1 (S1): registers in_data and computes fit.
- Stage 2 (S2): registers out_imm and out_fit, and drives the outputs.
- Error bookkeeping updates when S1 advances into S2 with fit = 0:
  - err_sticky is set to 1.
  - err_count increments unless it is already 255.
- err_clr has priority over a same-cycle error. After a clear in that cycle, sticky = 0 and count = 0.
- Each stage holds a valid bit. No data is dropped or duplicated under backpressure.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_imm = 0
  - out_fit = 0
  - err_sticky = 0
  - err_count = 0
- All pipeline contents are discarded on rst_n low, including reset asserted mid-stream.
- Latency: a value accepted in cycle N appears with out_valid = 1 in cycle N+2 when there is no stall.
- Throughput: one value per cycle while out_ready = 1.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv, which is combinational from out_ready.
- With out_ready = 0 and both stages full: in_ready = 0 and the outputs are held stable.
- out_valid, once asserted, is not deasserted until accepted.
- A simultaneous accept and emit in the same cycle is legal and keeps the pipeline full.

## Configuration
- SIGN_NARROW_SAT_EN defined: non-fitting values saturate.
  - in_data[7] = 0 gives out_imm = 5'b01111 (+15).
  - in_data[7] = 1 gives out_imm = 5'b10000 (-16).
- SIGN_NARROW_SAT_EN undefined: non-fitting values truncate, out_imm = in_data[4:0].
- out_fit and error bookkeeping are identical in both builds.

## Structure
- Shared package holds:
  - IMM5_W = 5 and DATA_W = 8
  - IMM5_MAX = 5'b01111 and IMM5_MIN = 5'b10000
  - ERR_CNT_MAX = 8'hFF
- One sub-module, narrow5_core: combinational fit check plus saturate/truncate selection, instantiated in S1.
- Pipeline valid logic, handshake and error registers stay in the top module.

## Test plan
- **Boundary values**, out_ready = 1, input stream 0x0F, 0xF0, 0x00, 0xFF:
  - out_imm = 0x0F, 0x10, 0x00, 0x1F
  - out_fit = 1 for all four
  - each output appears 2 cycles after its input
  - err_sticky stays 0
- **Out-of-range values** 0x10 and 0x80:
  - out_fit = 0 for both
  - SAT build: out_imm = 0x0F, then 0x10
  - non-SAT build: out_imm = 0x10, then 0x00
  - err_count = 2 and err_sticky = 1
- **Backpressure**: 4 values sent back-to-back with out_ready = 0 for 5 cycles:
  - in_ready drops after 2 acceptances
  - out_imm is held stable
  - after out_ready = 1, all 4 values emerge in order with no loss or duplicate
- **Counter saturation**: 260 non-fitting values, then err_clr pulsed in the same cycle as a further error:
  - err_count holds at 255
  - after the clear cycle, err_count = 0 and err_sticky = 0
- **Reset mid-operation**: rst_n asserted with both stages full:
  - out_valid = 0 and in_ready = 1 immediately (asynchronous)
  - no stale output appears after release
